// File: rtl/iiitb_fifo_pkg.sv
// rtl/iiitb_fifo_pkg.sv - shared defaults and read-mode encodings for iiitb_fifo_gen
package iiitb_fifo_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int MODE_STD   = 0;
    localparam int MODE_FWFT  = 1;
endpackage

// File: rtl/iiitb_fifo_ram.sv
// rtl/iiitb_fifo_ram.sv - DEPTH x DATA_W simple dual-port storage, sync write, async read
module iiitb_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/iiitb_fifo_gen.sv
// rtl/iiitb_fifo_gen.sv - parametrised synchronous FIFO with thresholds, sticky errors, flush, FWFT
module iiitb_fifo_gen
    import iiitb_fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int AF_LEVEL = (2**ADDR_W) - 1,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = MODE_STD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] buf_in,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              flush,
    input  logic              err_clr,
    output logic [DATA_W-1:0] buf_out,
    output logic              buf_empty,
    output logic              buf_full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   fifo_counter,
    output logic              overflow,
    output logic              underflow
);
    localparam int              DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] rdata;
    logic              rd_ok;
    logic              wr_ok;

    // Flags derive from the registered count only, so no input reaches an output combinationally.
    assign buf_empty    = (count == '0);
    assign buf_full     = (count == DEPTH_C);
    assign almost_empty = (count <= AE_C);
    assign almost_full  = (count >= AF_C);
    assign fifo_counter = count;

    assign rd_ok = rd_en & ~buf_empty;
    assign wr_ok = wr_en & (~buf_full | rd_ok);

    iiitb_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok & ~flush),
        .waddr (wr_ptr),
        .wdata (buf_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A new error outranks a same-cycle clear; flush suppresses error detection entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (!flush && wr_en && !wr_ok) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (!flush && rd_en && !rd_ok) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT == MODE_FWFT) begin : g_fwft
            assign buf_out = buf_empty ? '0 : rdata;
        end else begin : g_std
            logic [DATA_W-1:0] out_q;
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    out_q <= '0;
                end else if (rd_ok) begin
                    out_q <= rdata;
                end
            end
            assign buf_out = out_q;
        end
    endgenerate
endmodule

// File: tb/tb_iiitb_fifo_gen.sv
// tb/tb_iiitb_fifo_gen.sv - queue-model checked bench driving standard and FWFT instances in lockstep
module tb_iiitb_fifo_gen;
    import iiitb_fifo_pkg::*;

    localparam int DEPTH = 2**DEF_ADDR_W;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] buf_in = '0;
    logic       wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0, err_clr = 1'b0;

    logic [7:0] s_out, f_out;
    logic       s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
    logic       f_empty, f_full, f_ae, f_af, f_ovf, f_udf;
    logic [3:0] s_cnt, f_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    logic [7:0] q[$];
    bit         m_ovf, m_udf;
    logic [7:0] m_out;

    always #5 clk = ~clk;

    iiitb_fifo_gen #(.FWFT(MODE_STD)) dut_std (
        .clk(clk), .rst(rst), .buf_in(buf_in), .wr_en(wr_en), .rd_en(rd_en),
        .flush(flush), .err_clr(err_clr), .buf_out(s_out), .buf_empty(s_empty),
        .buf_full(s_full), .almost_empty(s_ae), .almost_full(s_af),
        .fifo_counter(s_cnt), .overflow(s_ovf), .underflow(s_udf)
    );

    iiitb_fifo_gen #(.FWFT(MODE_FWFT)) dut_fw (
        .clk(clk), .rst(rst), .buf_in(buf_in), .wr_en(wr_en), .rd_en(rd_en),
        .flush(flush), .err_clr(err_clr), .buf_out(f_out), .buf_empty(f_empty),
        .buf_full(f_full), .almost_empty(f_ae), .almost_full(f_af),
        .fifo_counter(f_cnt), .overflow(f_ovf), .underflow(f_udf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit w, input bit p, input bit f, input bit c,
                                input logic [7:0] d);
        bit rok, wok;
        if (r) begin
            q.delete(); m_ovf = 0; m_udf = 0; m_out = '0;
        end else if (f) begin
            q.delete(); m_out = '0;
            if (c) begin m_ovf = 0; m_udf = 0; end
        end else begin
            rok = p && (q.size() > 0);
            wok = w && (q.size() < DEPTH || rok);
            if (w && !wok) m_ovf = 1; else if (c) m_ovf = 0;
            if (p && !rok) m_udf = 1; else if (c) m_udf = 0;
            if (rok) m_out = q.pop_front();
            if (wok) q.push_back(d);
        end
    endtask

    task automatic step(input bit r, input bit w, input bit p, input bit f, input bit c,
                        input logic [7:0] d);
        rst = r; wr_en = w; rd_en = p; flush = f; err_clr = c; buf_in = d;
        @(posedge clk);
        model_update(r, w, p, f, c, d);
        #1;
        rst = 0; wr_en = 0; rd_en = 0; flush = 0; err_clr = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            automatic int n = q.size();
            chk("cnt_std",   32'(s_cnt),   32'(n));
            chk("cnt_fw",    32'(f_cnt),   32'(n));
            chk("empty",     32'(s_empty), 32'(n == 0));
            chk("full",      32'(s_full),  32'(n == DEPTH));
            chk("aempty",    32'(s_ae),    32'(n <= 1));
            chk("afull",     32'(s_af),    32'(n >= DEPTH - 1));
            chk("fw_flags",  32'({f_empty, f_full, f_ae, f_af}),
                             32'({s_empty, s_full, s_ae, s_af}));
            chk("ovf",       32'({s_ovf, f_ovf}), 32'({m_ovf, m_ovf}));
            chk("udf",       32'({s_udf, f_udf}), 32'({m_udf, m_udf}));
            chk("out_std",   32'(s_out),   32'(m_out));
            chk("out_fw",    32'(f_out),   (n > 0) ? 32'(q[0]) : 32'd0);
        end
    end

    initial begin
        step(1, 0, 0, 0, 0, 8'h00);
        chk_en = 1'b1;
        chk("rst_cnt", 32'(s_cnt), 0);
        chk("rst_flags", 32'({s_empty, s_ae, s_full, s_af, s_ovf, s_udf}), 32'b110000);
        chk("rst_out", 32'(s_out), 0);

        // Fill and overflow
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 0, 0, 0, 8'(i * 10));
            chk("fill_cnt", 32'(s_cnt), 32'(i));
            if (i == 7) chk("af_at7", 32'({s_af, s_full}), 32'b10);
        end
        chk("full_at8", 32'(s_full), 1);
        step(0, 1, 0, 0, 0, 8'd90);
        chk("ovf_set", 32'({s_ovf, s_cnt}), 32'({1'b1, 4'd8}));

        // Drain and underflow
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 1, 0, 0, 8'h00);
            chk("drain_out", 32'(s_out), 32'(i * 10));
        end
        chk("drain_empty", 32'(s_empty), 1);
        step(0, 0, 1, 0, 0, 8'h00);
        chk("udf_hold", 32'({s_udf, s_out}), 32'({1'b1, 8'd80}));

        // Push while full with a same-cycle pop
        step(0, 0, 0, 0, 1, 8'h00);
        for (int i = 1; i <= 8; i++) step(0, 1, 0, 0, 0, 8'(i * 10));
        step(0, 1, 1, 0, 0, 8'd99);
        chk("pp_full", 32'({s_cnt, s_out, s_ovf}), 32'({4'd8, 8'd10, 1'b0}));
        for (int i = 2; i <= 9; i++) begin
            step(0, 0, 1, 0, 0, 8'h00);
            chk("pp_drain", 32'(s_out), (i == 9) ? 32'd99 : 32'(i * 10));
        end

        // Push with pop on empty
        step(0, 1, 1, 0, 0, 8'd1);
        chk("pp_empty", 32'({s_cnt, s_udf}), 32'({4'd1, 1'b1}));
        step(0, 0, 1, 0, 0, 8'h00);

        // Wrap-around
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 0, 0, 8'(i));
            chk("wrap_cnt", 32'(s_cnt <= 4'd2), 1);
            step(0, 0, 1, 0, 0, 8'h00);
            chk("wrap_out", 32'(s_out), 32'(i));
        end

        // Flush and error clear
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 8'(100 + i));
        step(0, 1, 0, 1, 0, 8'hEE);
        chk("flush", 32'({s_cnt, s_empty, s_out, f_out, s_ovf, s_udf}),
            32'({4'd0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b1}));
        step(0, 1, 0, 0, 0, 8'h11);
        step(0, 0, 1, 0, 0, 8'h00);
        chk("flush_lost", 32'(s_out), 32'h11);
        step(0, 0, 0, 0, 1, 8'h00);
        chk("err_clr", 32'({s_ovf, s_udf}), 0);

        // FWFT
        step(0, 1, 0, 0, 0, 8'h5A);
        chk("fw_first", 32'(f_out), 32'h5A);
        step(0, 1, 0, 0, 0, 8'h3C);
        step(0, 0, 1, 0, 0, 8'h00);
        chk("fw_next", 32'(f_out), 32'h3C);
        step(0, 0, 1, 0, 0, 8'h00);
        chk("fw_empty", 32'({f_out, f_empty}), 32'({8'd0, 1'b1}));

        // Randomised traffic with varying fill bias
        for (int i = 0; i < 3000; i++) begin
            automatic int wp = (i / 300) % 3 == 0 ? 80 : ((i / 300) % 3 == 1 ? 25 : 50);
            step($urandom_range(249) == 0, $urandom_range(99) < wp, $urandom_range(99) < 50,
                 $urandom_range(59) == 0, $urandom_range(39) == 0, 8'($urandom));
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
